fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall  input  1  decode not accepting; hold decode-stage outputs.
REQ-005 SHALL have port redirect  input  1  taken branch/jump resolved in decode (beq/bne/BGEZ/BLEZ/BGTZ/BLTZ/J/JAL/JR/JALR).
REQ-006 SHALL have port redirect_pc  input  32  target byte address; bits [1:0] ignored, treated as 00.
REQ-007 SHALL have port imem_en  output  1  instruction memory read enable.
REQ-008 SHALL have port imem_addr  output  32  byte address of the read issued this cycle.
REQ-009 SHALL have port imem_dout  input  32  read data; valid the cycle after the matching imem_en=1 (synchronous RAM, 1-cycle latency).
REQ-010 SHALL have port instr  output  32  registered instruction presented to the control unit.
REQ-011 SHALL have port pc_out  output  32  registered byte address of instr.
REQ-012 SHALL have port pc_plus4  output  32  pc_out+4 (link value for JAL/JALR), combinational.
REQ-013 SHALL have port instr_valid  output  1  instr holds a real, non-killed instruction.

Function
REQ-014 SHALL hold internal state: pc_q (next issue address), pend_valid/pend_pc (read in flight), skid_valid/skid_instr/skid_pc (one-entry skid buffer), FSM state in {RUN, HOLD}.
REQ-015 SHALL drive imem_en = !rst && !stall and imem_addr = pc_q; pc_q[1:0] always 00.
REQ-016 SHALL, in RUN with stall=0: pc_q <= pc_q+4; pend_valid <= 1, pend_pc <= pc_q; instr/pc_out/instr_valid <= imem_dout/pend_pc/pend_valid.
REQ-017 SHALL compute all PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-018 SHALL, on stall=1 in RUN: move to HOLD; hold pc_q, instr, pc_out, instr_valid; capture imem_dout/pend_pc into skid if pend_valid; clear pend_valid.
REQ-019 SHALL, in HOLD with stall=1: hold all state; skid contents unchanged.
REQ-020 SHALL, in HOLD with stall=0: return to RUN; load instr/pc_out/instr_valid from skid_instr/skid_pc/skid_valid; clear skid_valid; issue pc_q and advance per REQ-016.
REQ-021 SHALL act on redirect only when stall=0; redirect with stall=1 is ignored (decode holds redirect until stall falls).
REQ-022 SHALL, on redirect with stall=0: pc_q <= {redirect_pc[31:2],2'b00}; mark the read issued this cycle killed (pend_valid <= 0); data arriving this cycle (branch delay slot) still loads into instr per REQ-016/REQ-020.
REQ-023 SHALL therefore insert exactly one bubble (instr_valid=0) after the delay slot; first target instruction valid at decode three cycles after the redirect cycle.
REQ-024 SHALL keep pc_plus4 = pc_out+4 with wrap per REQ-017.

Reset
REQ-025 SHALL, while rst=1, immediately force pc_q=RESET_PC, pend_valid=0, skid_valid=0, instr=32'h0000_0000 (NOP), pc_out=0, instr_valid=0, state RUN, imem_en=0.
REQ-026 SHALL, first cycle after rst falls with stall=0, issue RESET_PC; instr_valid first rises two edges after rst falls.
REQ-027 SHALL, on reset asserted mid-stall or mid-redirect, discard skid, in-flight read and pending target with no partial update.

Verification
REQ-028 Reset release, stall=0, RESET_PC=0 -> imem_addr 0,4,8...; instr_valid=1 with pc_out=0 at second edge, then pc_out increments by 4 each cycle.
REQ-029 Stall 3 cycles while pend_valid=1 -> imem_en=0, instr/pc_out frozen; on release instr = skid word, next cycle the following address; no instruction lost or duplicated.
REQ-030 Branch at pc_out=0x40, redirect_pc=0x100 -> delay slot 0x44 valid next, then one bubble (0x48 killed), then pc_out=0x100,0x104.
REQ-031 redirect=1 with stall=1 for 2 cycles then stall=0 -> redirect taken only in stall=0 cycle; pc_q unchanged before it.
REQ-032 pc_q=0xFFFF_FFF8, free-running -> issues 0xFFFF_FFFC then 0x0000_0000; pc_plus4 of 0xFFFF_FFFC is 0.
REQ-033 rst pulsed asynchronously during HOLD with skid_valid=1 -> outputs reset immediately; after release fetch restarts at RESET_PC, skid word never appears.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sync-RAM read pipeline with one-entry skid buffer,
// decode-side stall and branch redirect with a single delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [31:0] RST_PC =
    RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RST_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      instr_q      <= 32'h0;
      pc_out_q     <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    if (!stall) begin
      state_d = RUN;
      unique case (state_q)
        HOLD: begin
          instr_d      = skid_instr_q;
          pc_out_d     = skid_pc_q;
          valid_d      = skid_valid_q;
          skid_valid_d = 1'b0;
        end
        default: begin
          instr_d  = imem_dout;
          pc_out_d = pend_pc_q;
          valid_d  = pend_valid_q;
        end
      endcase
      // read issued alongside a redirect is the wrong path
      pend_pc_d    = pc_q;
      pend_valid_d = !redirect;
      pc_d = redirect ? (redirect_pc & 32'hFFFF_FFFC)
                      : pc_q + 32'd4;
    end else if (state_q == RUN) begin
      state_d      = HOLD;
      skid_valid_d = pend_valid_q;
      if (pend_valid_q) begin
        skid_instr_d = imem_dout;
        skid_pc_d    = pend_pc_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  assign imem_en     = !rst && !stall;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign pc_plus4    = pc_out_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand corner sequences and a
// random stall/branch run against a program-order reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr, imem_dout;
  logic [31:0] instr, pc_out, pc_plus4;
  logic        instr_valid;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_dout(imem_dout), .instr(instr),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_ff @(posedge clk)
    if (imem_en) imem_dout <= memf(imem_addr);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_out(input string nm,
                         input logic [31:0] pc);
    chk({nm, ".valid"}, {31'b0, instr_valid}, 32'd1);
    chk({nm, ".pc"}, pc_out, pc);
    chk({nm, ".instr"}, instr, memf(pc));
    chk({nm, ".plus4"}, pc_plus4, pc + 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc, tgt, t;
    bit          dly, st, rd, found;
    int          idle, seen;

    tbl[0]  = '{0, 0, 0, 1, 32'h0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 32'h4, 1, 32'h0};
    tbl[2]  = '{0, 0, 0, 1, 32'h8, 1, 32'h4};
    tbl[3]  = '{1, 0, 0, 0, 32'hC, 1, 32'h4};
    tbl[4]  = '{1, 0, 0, 0, 32'hC, 1, 32'h4};
    tbl[5]  = '{1, 0, 0, 0, 32'hC, 1, 32'h4};
    tbl[6]  = '{0, 0, 0, 1, 32'hC, 1, 32'h8};
    tbl[7]  = '{0, 0, 0, 1, 32'h10, 1, 32'hC};
    tbl[8]  = '{0, 1, 32'h103, 1, 32'h14, 1, 32'h10};
    tbl[9]  = '{0, 0, 0, 1, 32'h100, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 32'h104, 1, 32'h100};
    tbl[11] = '{0, 0, 0, 1, 32'h108, 1, 32'h104};
    tbl[12] = '{1, 1, 32'h202, 0, 32'h10C, 1, 32'h104};
    tbl[13] = '{1, 1, 32'h202, 0, 32'h10C, 1, 32'h104};
    tbl[14] = '{0, 1, 32'h202, 1, 32'h10C, 1, 32'h108};
    tbl[15] = '{0, 0, 0, 1, 32'h200, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 32'h204, 1, 32'h200};
    tbl[17] = '{0, 1, 32'hFFFF_FFF8, 1, 32'h208, 1, 32'h204};
    tbl[18] = '{0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0};
    tbl[19] = '{0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8};
    tbl[20] = '{0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC};
    tbl[21] = '{0, 0, 0, 1, 32'h4, 1, 32'h0};

    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.en", {31'b0, imem_en}, 32'd0);
    chk("rst.addr", imem_addr, RPC);
    chk("rst.valid", {31'b0, instr_valid}, 32'd0);
    chk("rst.pc", pc_out, 32'h0);
    chk("rst.instr", instr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      stall = tbl[i].s;
      redirect = tbl[i].r;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d.en", i), {31'b0, imem_en},
          {31'b0, tbl[i].en});
      chk($sformatf("row%0d.addr", i), imem_addr, tbl[i].addr);
      @(negedge clk);
      if (tbl[i].v) chk_out($sformatf("row%0d", i), tbl[i].pc);
      else chk($sformatf("row%0d.valid", i),
               {31'b0, instr_valid}, 32'd0);
    end

    do_reset();
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (instr_valid && pc_out == 32'h40) found = 1;
    end
    chk("br.find40", {31'b0, found}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk_out("br.slot", 32'h44);
    @(negedge clk);
    chk("br.bubble", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk_out("br.tgt0", 32'h100);
    @(negedge clk);
    chk_out("br.tgt1", 32'h104);

    stall = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", {31'b0, instr_valid}, 32'd0);
    chk("arst.pc", pc_out, 32'h0);
    chk("arst.instr", instr, 32'h0);
    chk("arst.en", {31'b0, imem_en}, 32'd0);
    chk("arst.addr", imem_addr, RPC);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 4; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        chk($sformatf("arst.seq%0d.pc", seen), pc_out,
            RPC + 32'(4 * seen));
        chk($sformatf("arst.seq%0d.instr", seen), instr,
            memf(RPC + 32'(4 * seen)));
        seen++;
      end
    end
    chk("arst.count", 32'(seen), 32'd4);

    do_reset();
    exp_pc = RPC;
    dly = 0;
    tgt = 0;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      st = ($urandom_range(2) == 0);
      rd = 0;
      t = $urandom;
      if (instr_valid && !st) begin
        idle = 0;
        chk("rnd.pc", pc_out, exp_pc);
        chk("rnd.instr", instr, memf(pc_out));
        if (dly) begin
          exp_pc = tgt;
          dly = 0;
        end else if ($urandom_range(4) == 0) begin
          rd = 1;
          tgt = t & 32'hFFFF_FFFC;
          exp_pc = pc_out + 32'd4;
          dly = 1;
        end else begin
          exp_pc = pc_out + 32'd4;
        end
      end else begin
        idle++;
      end
      if (idle > 30) begin
        total++;
        $display("FAIL rnd.liveness: got %0d idle want <=30", idle);
        break;
      end
      stall = st;
      redirect = rd;
      redirect_pc = t;
      #1;
      chk("rnd.en", {31'b0, imem_en}, {31'b0, !st});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
